// File: rtl/hospital_rover_pkg.sv
// ============================================================================
// Module : hospital_rover_pkg
// Brief  : Room codes, navigator state/error encodings and rover move model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hospital_rover_pkg;

  localparam logic [2:0] c_HNR  = 3'd0;
  localparam logic [2:0] c_IR   = 3'd1;
  localparam logic [2:0] c_CPR  = 3'd2;
  localparam logic [2:0] c_ABIR = 3'd3;
  localparam logic [2:0] c_NPR  = 3'd4;
  localparam logic [2:0] c_ICU  = 3'd5;
  localparam logic [2:0] c_CCU  = 3'd6;
  localparam logic [2:0] c_BU   = 3'd7;

  typedef enum logic [1:0] {
    NAV_IDLE  = 2'd0,
    NAV_NAV   = 2'd1,
    NAV_FAULT = 2'd2
  } nav_state_t;

  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_MISMATCH = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;

  // Room the rover occupies after one edge, given its room and move bit.
  function automatic logic [2:0] next_room(input logic [2:0] loc, input logic mv);
    logic [2:0] nxt;
    nxt = c_HNR;
    case (loc)
      c_HNR:  nxt = mv ? c_IR   : c_HNR;
      c_IR:   nxt = mv ? c_ICU  : c_HNR;
      c_CPR:  nxt = mv ? c_BU   : c_ABIR;
      c_ABIR: nxt = mv ? c_NPR  : c_HNR;
      c_NPR:  nxt = mv ? c_ICU  : c_HNR;
      c_ICU:  nxt = mv ? c_CPR  : c_NPR;
      c_CCU:  nxt = mv ? c_ABIR : c_HNR;
      c_BU:   nxt = mv ? c_ICU  : c_CCU;
      default: nxt = c_HNR;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rover_route_rom.sv
// ============================================================================
// Module : rover_route_rom
// Brief  : Shortest-path move bit for every {current room, destination} pair.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rover_route_rom
  import hospital_rover_pkg::*;
(
  input  logic [2:0] i_cur_loc,
  input  logic [2:0] i_dest,
  output logic       o_nav_bit
);

  logic [7:0] w_row;

  // Row per destination, bit index = current room; ties in BFS distance pick 0.
  always_comb begin
    w_row = 8'b0000_0000;
    case (i_dest)
      c_HNR:  w_row = 8'b0000_0000;
      c_IR:   w_row = 8'b0000_0001;
      c_CPR:  w_row = 8'b1011_1011;
      c_ABIR: w_row = 8'b0111_0011;
      c_NPR:  w_row = 8'b1100_1011;
      c_ICU:  w_row = 8'b1001_1111;
      c_CCU:  w_row = 8'b0011_1111;
      c_BU:   w_row = 8'b0011_1111;
      default: w_row = 8'b0000_0000;
    endcase
  end

  assign o_nav_bit = w_row[i_cur_loc];

endmodule

`default_nettype wire

// File: rtl/rover_route_navigator.sv
// ============================================================================
// Module : rover_route_navigator
// Brief  : Steers the rover to a requested room, checking every predicted hop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rover_route_navigator
  import hospital_rover_pkg::*;
#(
  parameter int MAX_HOPS = 7,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [2:0]       req_dest,
  output logic             req_ready,
  input  logic [2:0]       current_loc,
  output logic             move_switch,
  output logic             busy,
  output logic             arrived,
  output logic [CNT_W-1:0] hop_count,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] c_MAX_HOPS = CNT_W'(MAX_HOPS);

  nav_state_t       r_state;
  nav_state_t       w_state_next;
  logic [2:0]       r_dest_q;
  logic [2:0]       r_exp_loc_q;
  logic             r_exp_vld;
  logic [CNT_W-1:0] r_hop_count;
  logic             r_arrived;
  logic [1:0]       r_err_code;

  logic             w_nav_bit;
  logic             w_move;
  logic             w_accept;
  logic             w_arrive;
  logic             w_step;
  logic             w_fault_set;
  logic [1:0]       w_fault_code;

  rover_route_rom u_rom (
    .i_cur_loc (current_loc),
    .i_dest    (r_dest_q),
    .o_nav_bit (w_nav_bit)
  );

  always_comb begin
    w_state_next = r_state;
    w_move       = 1'b0;
    w_accept     = 1'b0;
    w_arrive     = 1'b0;
    w_step       = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_code = c_ERR_NONE;
    case (r_state)
      NAV_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = NAV_NAV;
        end
      end
      NAV_NAV: begin
        // Mismatch outranks arrival: a wrong room that happens to be the
        // destination still means the rover did not follow our command.
        if (r_exp_vld && (current_loc != r_exp_loc_q)) begin
          w_fault_set  = 1'b1;
          w_fault_code = c_ERR_MISMATCH;
          w_state_next = NAV_FAULT;
        end else if (current_loc == r_dest_q) begin
          w_arrive     = 1'b1;
          w_state_next = NAV_IDLE;
        end else if (r_hop_count == c_MAX_HOPS) begin
          w_fault_set  = 1'b1;
          w_fault_code = c_ERR_TIMEOUT;
          w_state_next = NAV_FAULT;
        end else begin
          w_move = w_nav_bit;
          w_step = 1'b1;
        end
      end
      NAV_FAULT: begin
        if (clr_err) begin
          w_state_next = NAV_IDLE;
        end
      end
      default: w_state_next = NAV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= NAV_IDLE;
      r_dest_q    <= c_HNR;
      r_exp_loc_q <= c_HNR;
      r_exp_vld   <= 1'b0;
      r_hop_count <= '0;
      r_arrived   <= 1'b0;
      r_err_code  <= c_ERR_NONE;
    end else begin
      r_state   <= w_state_next;
      r_arrived <= w_arrive;
      if (w_accept) begin
        r_dest_q    <= req_dest;
        r_hop_count <= '0;
        r_exp_vld   <= 1'b0;
      end
      if (w_step) begin
        r_exp_loc_q <= next_room(current_loc, w_move);
        r_exp_vld   <= 1'b1;
        if (r_hop_count != c_MAX_HOPS) begin
          r_hop_count <= r_hop_count + 1'b1;
        end
      end
      if (w_fault_set) begin
        r_err_code <= w_fault_code;
      end else if ((r_state == NAV_FAULT) && clr_err) begin
        r_err_code <= c_ERR_NONE;
      end
    end
  end

  assign move_switch = w_move;
  assign req_ready   = (r_state == NAV_IDLE);
  assign busy        = (r_state == NAV_NAV);
  assign err         = (r_state == NAV_FAULT);
  assign err_code    = r_err_code;
  assign arrived     = r_arrived;
  assign hop_count   = r_hop_count;

endmodule

`default_nettype wire

// File: tb/tb_rover_route_navigator.sv
// ============================================================================
// Module : tb_rover_route_navigator
// Brief  : Directed checks of the navigator driving a behavioural rover.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rover_route_navigator;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       req_valid_a, clr_err_a, ovr_en;
  logic [2:0] req_dest_a, ovr_loc, loc_a;
  logic       ready_a, move_a, busy_a, arrived_a, err_a;
  logic [2:0] hop_a;
  logic [1:0] code_a;

  logic       req_valid_b, clr_err_b;
  logic [2:0] req_dest_b, loc_b;
  logic       ready_b, move_b, busy_b, arrived_b, err_b;
  logic [2:0] hop_b;
  logic [1:0] code_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  rover_route_navigator dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_a), .req_dest(req_dest_a),
    .req_ready(ready_a), .current_loc(loc_a), .move_switch(move_a), .busy(busy_a),
    .arrived(arrived_a), .hop_count(hop_a), .err(err_a), .err_code(code_a),
    .clr_err(clr_err_a)
  );

  rover_route_navigator #(.MAX_HOPS(3), .CNT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_dest(req_dest_b),
    .req_ready(ready_b), .current_loc(loc_b), .move_switch(move_b), .busy(busy_b),
    .arrived(arrived_b), .hop_count(hop_b), .err(err_b), .err_code(code_b),
    .clr_err(clr_err_b)
  );

  // Behavioural rover, independent of the design's own table.
  function automatic logic [2:0] rover_step(input logic [2:0] loc, input logic mv);
    case (loc)
      3'd0: return mv ? 3'd1 : 3'd0;
      3'd1: return mv ? 3'd5 : 3'd0;
      3'd2: return mv ? 3'd7 : 3'd3;
      3'd3: return mv ? 3'd4 : 3'd0;
      3'd4: return mv ? 3'd5 : 3'd0;
      3'd5: return mv ? 3'd2 : 3'd4;
      3'd6: return mv ? 3'd3 : 3'd0;
      default: return mv ? 3'd5 : 3'd6;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      loc_a <= 3'd0;
      loc_b <= 3'd0;
    end else begin
      loc_a <= ovr_en ? ovr_loc : rover_step(loc_a, move_a);
      loc_b <= rover_step(loc_b, move_b);
    end
  end

  task automatic request_a(input logic [2:0] dest);
    @(negedge clk);
    req_valid_a = 1'b1;
    req_dest_a  = dest;
    @(negedge clk);
    req_valid_a = 1'b0;
  endtask

  task automatic check_idle_outputs_a(input string tag);
    n_checks++;
    if ({move_a, ready_a, busy_a, arrived_a, err_a} !== 5'b01000) begin
      n_fails++;
      $display("FAIL %s flags: got move/ready/busy/arr/err=%b required 01000", tag,
               {move_a, ready_a, busy_a, arrived_a, err_a});
    end
    n_checks++;
    if (hop_a !== 3'd0 || code_a !== 2'b00) begin
      n_fails++;
      $display("FAIL %s hop/code: got %0d/%b required 0/00", tag, hop_a, code_a);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_idle_outputs_a("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clr_err_a = 1'b1;
    @(negedge clk);
    clr_err_a = 1'b0;
    n_checks++;
    if (ready_a !== 1'b1 || err_a !== 1'b0) begin
      n_fails++;
      $display("FAIL clr_err_idle: got ready=%b err=%b required 1/0", ready_a, err_a);
    end
  endtask

  // Drives a request from HNR and checks the move bit for each NAV cycle.
  task automatic run_path(input string tag, input logic [2:0] dest, input int hops,
                          input logic [7:0] bits);
    request_a(dest);
    for (int i = 0; i < hops; i++) begin
      n_checks++;
      if (move_a !== bits[i] || busy_a !== 1'b1) begin
        n_fails++;
        $display("FAIL %s move[%0d]: got move=%b busy=%b required %b/1", tag, i, move_a,
                 busy_a, bits[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (move_a !== 1'b0 || loc_a !== dest) begin
      n_fails++;
      $display("FAIL %s final: got move=%b loc=%0d required 0/%0d", tag, move_a, loc_a, dest);
    end
    @(negedge clk);
    n_checks++;
    if (arrived_a !== 1'b1 || hop_a !== 3'(hops) || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fails++;
      $display("FAIL %s arrive: got arr=%b hop=%0d ready=%b busy=%b required 1/%0d/1/0", tag,
               arrived_a, hop_a, ready_a, busy_a, hops);
    end
    @(negedge clk);
    n_checks++;
    if (arrived_a !== 1'b0 || hop_a !== 3'(hops)) begin
      n_fails++;
      $display("FAIL %s pulse: got arr=%b hop=%0d required 0/%0d", tag, arrived_a, hop_a, hops);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_bu_path();
    run_path("hnr_bu", 3'd7, 4, 8'b0000_1111);
  endtask

  task automatic test_ccu_path();
    run_path("hnr_ccu", 3'd6, 5, 8'b0000_1111);
    n_checks++;
    if (loc_a !== 3'd0) begin
      n_fails++;
      $display("FAIL ccu_park: got loc=%0d required 0", loc_a);
    end
  endtask

  task automatic test_self_dest();
    run_path("hnr_hnr", 3'd0, 0, 8'b0000_0000);
  endtask

  task automatic test_mismatch();
    request_a(3'd7);
    ovr_en  = 1'b1;
    ovr_loc = 3'd3;
    @(negedge clk);
    ovr_en = 1'b0;
    n_checks++;
    if (move_a !== 1'b0 || hop_a !== 3'd1) begin
      n_fails++;
      $display("FAIL mism_cycle: got move=%b hop=%0d required 0/1", move_a, hop_a);
    end
    @(negedge clk);
    n_checks++;
    if (err_a !== 1'b1 || code_a !== 2'b01 || ready_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fails++;
      $display("FAIL mism_fault: got err=%b code=%b ready=%b busy=%b required 1/01/0/0",
               err_a, code_a, ready_a, busy_a);
    end
    req_valid_a = 1'b1;
    req_dest_a  = 3'd0;
    @(negedge clk);
    req_valid_a = 1'b0;
    n_checks++;
    if (err_a !== 1'b1 || code_a !== 2'b01 || move_a !== 1'b0) begin
      n_fails++;
      $display("FAIL mism_sticky: got err=%b code=%b move=%b required 1/01/0", err_a, code_a,
               move_a);
    end
    clr_err_a = 1'b1;
    @(negedge clk);
    clr_err_a = 1'b0;
    n_checks++;
    if (err_a !== 1'b0 || code_a !== 2'b00 || ready_a !== 1'b1) begin
      n_fails++;
      $display("FAIL mism_clear: got err=%b code=%b ready=%b required 0/00/1", err_a, code_a,
               ready_a);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_nav();
    request_a(3'd7);
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || move_a !== 1'b1) begin
      n_fails++;
      $display("FAIL midrst_pre: got busy=%b move=%b required 1/1", busy_a, move_a);
    end
    #2 reset_n = 1'b0;
    #1 check_idle_outputs_a("midrst_async");
    repeat (2) @(negedge clk);
    check_idle_outputs_a("midrst_held");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    req_valid_b = 1'b1;
    req_dest_b  = 3'd6;
    @(negedge clk);
    req_dest_b = 3'd0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (move_b !== 1'b1 || busy_b !== 1'b1 || hop_b !== 3'(i)) begin
        n_fails++;
        $display("FAIL tmo_move[%0d]: got move=%b busy=%b hop=%0d required 1/1/%0d", i, move_b,
                 busy_b, hop_b, i);
      end
      @(negedge clk);
    end
    n_checks++;
    if (move_b !== 1'b0 || hop_b !== 3'd3 || loc_b !== 3'd2) begin
      n_fails++;
      $display("FAIL tmo_limit: got move=%b hop=%0d loc=%0d required 0/3/2", move_b, hop_b,
               loc_b);
    end
    @(negedge clk);
    req_valid_b = 1'b0;
    n_checks++;
    if (err_b !== 1'b1 || code_b !== 2'b10 || hop_b !== 3'd3 || ready_b !== 1'b0) begin
      n_fails++;
      $display("FAIL tmo_fault: got err=%b code=%b hop=%0d ready=%b required 1/10/3/0", err_b,
               code_b, hop_b, ready_b);
    end
    clr_err_b = 1'b1;
    @(negedge clk);
    clr_err_b = 1'b0;
    n_checks++;
    if (err_b !== 1'b0 || code_b !== 2'b00 || ready_b !== 1'b1 || hop_b !== 3'd3) begin
      n_fails++;
      $display("FAIL tmo_clear: got err=%b code=%b ready=%b hop=%0d required 0/00/1/3", err_b,
               code_b, ready_b, hop_b);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid_a = 1'b0;
    req_dest_a  = 3'd0;
    clr_err_a   = 1'b0;
    ovr_en      = 1'b0;
    ovr_loc     = 3'd0;
    req_valid_b = 1'b0;
    req_dest_b  = 3'd0;
    clr_err_b   = 1'b0;
    test_reset();
    test_bu_path();
    test_ccu_path();
    test_self_dest();
    test_mismatch();
    test_reset_mid_nav();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
